// File: rtl/majority_seq_pkg.sv
// Shared types for the sequential majority voter: FSM state encoding and count-width helper.
package majority_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/majority_seq_popcount_lanes.sv
// Combinational popcount of LANES bits; zero latency, no handshake.
module popcount_lanes #(
  parameter int LANES = 4
) (
  input  logic [LANES-1:0]            bits,
  output logic [$clog2(LANES+1)-1:0]  count
);

  localparam int OW = $clog2(LANES + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < LANES; i++) begin
      count = count + OW'(bits[i]);
    end
  end

endmodule

// File: rtl/majority_seq.sv
// Sequential majority/threshold voter: one word per WIDTH/LANES+2 cycles, result valid WIDTH/LANES edges after accept.
// Result holds in DONE until out_ready; no new word is taken while counting or holding a result.
module majority_seq
  import majority_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LANES    = 4,
  parameter bit TIE_MODE = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         thr_en,
  input  logic [cnt_w(WIDTH)-1:0]      thr_val,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [cnt_w(WIDTH)-1:0]      out_count,
  output logic                         out_major,
  output logic                         out_tie
);

  localparam int CW   = cnt_w(WIDTH);
  localparam int PW   = $clog2(LANES + 1);
  localparam int C    = WIDTH / LANES;
  localparam int CTRW = (C > 1) ? $clog2(C) : 1;

  if ((WIDTH < 2) || (LANES < 1) || ((WIDTH % LANES) != 0)) begin : g_param_check
    $error("majority_seq: WIDTH must be >= 2 and a multiple of LANES");
  end

  state_t            state, state_n;
  logic [WIDTH-1:0]  shift;
  logic [CW-1:0]     acc;
  logic [CTRW-1:0]   ctr;
  logic              thr_en_q;
  logic [CW-1:0]     thr_val_q;
  logic              accept;
  logic [PW-1:0]     pc;

  popcount_lanes #(.LANES(LANES)) u_pc (
    .bits  (shift[LANES-1:0]),
    .count (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_n = COUNT;
        end
      end
      COUNT: begin
        if (ctr == CTRW'(C - 1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift     <= '0;
      acc       <= '0;
      ctr       <= '0;
      thr_en_q  <= 1'b0;
      thr_val_q <= '0;
    end else if (accept) begin
      shift     <= in_data;
      acc       <= '0;
      ctr       <= '0;
      thr_en_q  <= thr_en;
      thr_val_q <= thr_val;
    end else if (state == COUNT) begin
      acc   <= acc + CW'(pc);
      shift <= shift >> LANES;
      ctr   <= ctr + CTRW'(1);
    end
  end

  // Decisions use one extra bit so doubling the count never wraps.
  logic [CW:0] cnt2, wid, acc_x, thr_x;
  logic        tie, major_maj, major_thr;

  always_comb begin
    cnt2      = {acc, 1'b0};
    wid       = (CW + 1)'(WIDTH);
    acc_x     = {1'b0, acc};
    thr_x     = {1'b0, thr_val_q};
    tie       = (cnt2 == wid);
    major_maj = (cnt2 > wid) | (tie & TIE_MODE);
    major_thr = (acc_x >= thr_x);
  end

  always_comb begin
    out_count = out_valid ? acc : '0;
    out_tie   = out_valid & tie;
    out_major = out_valid & (thr_en_q ? major_thr : major_maj);
  end

endmodule
